// File: rtl/friscv_ram_responder_if.sv
// Request/response channel bundle between an initiator and the RAM responder.
// master = initiator side, slave = responder side.
interface friscv_ram_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_wr;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_wr, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_wr, rsp_rdata
  );
endinterface

// File: rtl/friscv_ram_responder.sv
// Byte-enabled single-cycle RAM behind a valid/ready request channel, with an
// in-order response FIFO that absorbs initiator back-pressure.
module friscv_ram_responder #(
  parameter int INIT       = 0,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input logic                  aclk,
  input logic                  aresetn,
  friscv_ram_responder_if.slave bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_DEPTH + 1);

  logic                  ready_q;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         outstanding_nxt;

  logic                  pend_valid;
  logic                  pend_wr;
  logic [ADDR_WIDTH-1:0] pend_addr;

  logic                  fifo_wr   [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         fifo_cnt;

  logic                  rsp_valid_q;
  logic                  rsp_wr_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  req_hs;
  logic                  rsp_hs;
  logic                  load_out;
  logic                  from_fifo;
  logic                  to_fifo;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] push_data;

  assign req_hs        = bus.req_valid & ready_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Both branches expose the array as g_mem; only the declaration differs.
  if (INIT != 0) begin : g_mem
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge aclk) begin
      if (req_hs && bus.req_wr) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (bus.req_be[i]) mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end

    assign rd_word = mem[pend_addr];
  end else begin : g_mem
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
      if (req_hs && bus.req_wr) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (bus.req_be[i]) mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end

    assign rd_word = mem[pend_addr];
  end

  // The output register is the FIFO head; the FIFO is bypassed when it is empty
  // and the output register is free, so a response is never reordered.
  always_comb begin
    rsp_hs          = rsp_valid_q & bus.rsp_ready;
    outstanding_nxt = outstanding;
    if (req_hs && !rsp_hs)      outstanding_nxt = outstanding + 1'b1;
    else if (!req_hs && rsp_hs) outstanding_nxt = outstanding - 1'b1;
    push_data = pend_wr ? '0 : rd_word;
    load_out  = !rsp_valid_q || rsp_hs;
    from_fifo = load_out && (fifo_cnt != '0);
    to_fifo   = pend_valid && !(load_out && (fifo_cnt == '0));
  end

  always_ff @(posedge aclk) begin
    if (to_fifo) begin
      fifo_wr[wptr]   <= pend_wr;
      fifo_data[wptr] <= push_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q     <= 1'b0;
      outstanding <= '0;
      pend_valid  <= 1'b0;
      pend_wr     <= 1'b0;
      pend_addr   <= '0;
      wptr        <= '0;
      rptr        <= '0;
      fifo_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      ready_q     <= (outstanding_nxt < CW'(RSP_DEPTH));
      pend_valid  <= req_hs;
      if (req_hs) begin
        pend_wr   <= bus.req_wr;
        pend_addr <= bus.req_addr;
      end
      if (to_fifo)   wptr <= wptr + 1'b1;
      if (from_fifo) rptr <= rptr + 1'b1;
      if (to_fifo && !from_fifo)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!to_fifo && from_fifo) fifo_cnt <= fifo_cnt - 1'b1;
      if (load_out) begin
        if (from_fifo) begin
          rsp_valid_q <= 1'b1;
          rsp_wr_q    <= fifo_wr[rptr];
          rsp_rdata_q <= fifo_data[rptr];
        end else if (pend_valid) begin
          rsp_valid_q <= 1'b1;
          rsp_wr_q    <= pend_wr;
          rsp_rdata_q <= push_data;
        end else begin
          rsp_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_friscv_ram_responder.sv
// Self-checking bench for friscv_ram_responder: table vectors plus hand-written
// back-pressure, overlap, streaming and mid-burst reset sequences.
module tb_friscv_ram_responder;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  friscv_ram_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  friscv_ram_responder #(
    .INIT(0), .ADDR_WIDTH(8), .DATA_WIDTH(32), .RSP_DEPTH(2)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[12];
  logic [31:0] model [256];
  logic [7:0]  bp_addr [3];
  int          checks = 0;
  int          errors = 0;
  int          rsp_count = 0;
  int          acc;
  int          rsp_base;
  bit          seen;
  bit          done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] rdata);
    exp_t e;
    e.wr = wr;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic wr, input logic [7:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic exp_wr, input logic [31:0] exp_rdata);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wdata;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (bus.req_ready) begin
        push_exp(exp_wr, exp_rdata);
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) model[addr][8*b +: 8] = wdata[8*b +: 8];
          end
        end
        @(posedge aclk); #1;
        return;
      end
      @(posedge aclk); #1;
    end
    checks++;
    errors++;
    $display("FAIL req_timeout: got req_ready=0 for 100 cycles, required acceptance");
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk); #1;
      if (exp_q.size() == 0) begin
        @(posedge aclk); #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d responses pending, required 0", exp_q.size());
    exp_q.delete();
  endtask

  always @(negedge aclk) begin
    if (aresetn && bus.rsp_valid && bus.rsp_ready) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got wr=%0b rdata=%h, required no response",
                 bus.rsp_wr, bus.rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp", {31'd0, bus.rsp_wr, bus.rsp_rdata}, {31'd0, e.wr, e.rdata});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 8'h10, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 8'h20, 4'hF, 32'h11223344, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 8'h20, 4'h5, 32'hAABBCCDD, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 8'h20, 4'h0, 32'h0,        1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 8'h20, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 8'h20, 4'h0, 32'h0,        1'b0, 32'h11BB33DD};
    vecs[7]  = '{1'b1, 8'hFF, 4'hF, 32'h01020304, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 8'hFF, 4'h8, 32'hA5FFFFFF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 8'hFF, 4'h0, 32'h0,        1'b0, 32'hA5020304};
    vecs[10] = '{1'b1, 8'h00, 4'h3, 32'h7777BEEF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 8'h10, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
    bp_addr[0] = 8'd1;
    bp_addr[1] = 8'd2;
    bp_addr[2] = 8'd3;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_wr", bus.rsp_wr, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    @(posedge aclk); #1;

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata,
           vecs[i].exp_wr, vecs[i].exp_rdata);
    end
    idle();
    drain();

    // Back-pressure with a full buffer
    for (int i = 0; i < 3; i++) send(1'b1, bp_addr[i], 4'hF, 32'h5A000000 + i, 1'b1, 32'h0);
    idle();
    drain();
    bus.rsp_ready = 1'b0;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_be    = 4'h0;
    bus.req_addr  = bp_addr[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (bus.req_valid && bus.req_ready) begin
        push_exp(1'b0, model[bus.req_addr]);
        acc++;
      end
      @(posedge aclk); #1;
      if (acc < 3) bus.req_addr = bp_addr[acc];
      else idle();
    end
    check("bp_accepted", acc, 2);
    check("bp_ready_low", bus.req_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge aclk);
      if (seen) begin
        check("bp_ready_after_hs", bus.req_ready, 1'b1);
        done = 1'b1;
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        check("bp_ready_at_hs", bus.req_ready, 1'b0);
        seen = 1'b1;
      end
      if (bus.req_valid && bus.req_ready) begin
        push_exp(1'b0, model[bus.req_addr]);
        acc++;
      end
      @(posedge aclk); #1;
      if (acc == 3) idle();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL bp_timeout: got no response handshake, required one within 20 cycles");
    end
    idle();
    drain();

    // Request and response handshake in the same cycle at outstanding=1
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h10, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF);
    idle();
    @(posedge aclk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h20;
    @(negedge aclk);
    check("sim_both_ready", {bus.rsp_valid, bus.req_ready}, 2'b11);
    if (bus.req_ready) push_exp(1'b0, 32'h11BB33DD);
    @(posedge aclk); #1;
    idle();
    @(negedge aclk);
    check("sim_ready_hold", bus.req_ready, 1'b1);
    check("sim_rsp_gap", bus.rsp_valid, 1'b0);
    @(posedge aclk); #1;
    drain();

    // Streaming alternating write/read to one address
    rsp_base = rsp_count;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) send(1'b1, 8'h40, 4'hF, 32'h1000 + i, 1'b1, 32'h0);
      else            send(1'b0, 8'h40, 4'h0, 32'h0, 1'b0, 32'h1000 + i - 1);
    end
    idle();
    drain();
    check("stream_count", rsp_count - rsp_base, 64);

    // Reset with two buffered responses
    bus.rsp_ready = 1'b0;
    send(1'b1, 8'h80, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0);
    send(1'b1, 8'h81, 4'hF, 32'h0BADC0DE, 1'b1, 32'h0);
    idle();
    repeat (3) @(posedge aclk);
    #3;
    check("rb_buffered", bus.rsp_valid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("rb_async_clear", bus.rsp_valid, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    check("rb_ready_after", bus.req_ready, 1'b1);
    check("rb_valid_after", bus.rsp_valid, 1'b0);
    @(posedge aclk); #1;
    bus.rsp_ready = 1'b1;
    send(1'b0, 8'h80, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D);
    send(1'b0, 8'h81, 4'h0, 32'h0, 1'b0, 32'h0BADC0DE);
    idle();
    drain();
    repeat (3) @(posedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
